// File: rtl/ste_snd_pkg.sv
// Shared constants for the STE Microwire / LMC1992 sound path: command codes,
// reset defaults, mix modes and the 2 dB-per-step attenuation table.
package ste_snd_pkg;

  localparam logic [1:0] LMC_ADDR = 2'b10;

  localparam logic [2:0] FN_MIX    = 3'b000;
  localparam logic [2:0] FN_BASS   = 3'b001;
  localparam logic [2:0] FN_TREBLE = 3'b010;
  localparam logic [2:0] FN_MASTER = 3'b011;
  localparam logic [2:0] FN_RIGHT  = 3'b100;
  localparam logic [2:0] FN_LEFT   = 3'b101;

  typedef enum logic [1:0] {
    MIX_M12DB  = 2'b00,
    MIX_YM     = 2'b01,
    MIX_OFF    = 2'b10,
    MIX_YM_ALT = 2'b11
  } mix_e;

  typedef enum logic [1:0] {
    MW_IDLE  = 2'd0,
    MW_SHIFT = 2'd1,
    MW_LATCH = 2'd2
  } mw_state_e;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_LEFT   = 5'd20;
  localparam logic [4:0] RST_RIGHT  = 5'd20;
  localparam mix_e       RST_MIX    = MIX_YM;
  localparam logic [3:0] RST_BASS   = 4'd6;
  localparam logic [3:0] RST_TREBLE = 4'd6;

  // round(65535 * 10^(-n/10)), Q0.16
  localparam logic [15:0] GAIN_LUT [0:60] = '{
    16'd65535, 16'd52056, 16'd41350, 16'd32845, 16'd26090,
    16'd20724, 16'd16462, 16'd13076, 16'd10387, 16'd8250,
    16'd6554,  16'd5206,  16'd4135,  16'd3285,  16'd2609,
    16'd2072,  16'd1646,  16'd1308,  16'd1039,  16'd825,
    16'd655,   16'd521,   16'd413,   16'd328,   16'd261,
    16'd207,   16'd165,   16'd131,   16'd104,   16'd83,
    16'd66,    16'd52,    16'd41,    16'd33,    16'd26,
    16'd21,    16'd16,    16'd13,    16'd10,    16'd8,
    16'd7,     16'd5,     16'd4,     16'd3,     16'd3,
    16'd2,     16'd2,     16'd1,     16'd1,     16'd1,
    16'd1,     16'd1,     16'd0,     16'd0,     16'd0,
    16'd0,     16'd0,     16'd0,     16'd0,     16'd0,
    16'd0
  };

  // Settings are clamped on load, so neither difference can go negative.
  function automatic logic [5:0] atten_idx(input logic [5:0] master, input logic [4:0] side);
    return (6'd40 - master) + (6'd20 - {1'b0, side});
  endfunction

endpackage

// File: rtl/lmc_channel.sv
// One stereo channel: YM mix mode, saturating sum with DMA sound, then gain
// from the attenuation table. Two register stages from input to output.
module lmc_channel
  import ste_snd_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic                 clk_8,
  input  logic                 reset_n,
  input  mix_e                 mix,
  input  logic signed [AW-1:0] ym_in,
  input  logic signed [AW-1:0] dma_in,
  input  logic [5:0]           atten,
  output logic signed [AW-1:0] audio_out
);

  logic signed [AW:0]    ym_ext;
  logic signed [AW:0]    ym_mix;
  logic signed [AW:0]    sum_w;
  logic signed [AW-1:0]  sum_sat;
  logic signed [AW-1:0]  sum_q;
  logic [15:0]           gain_q;
  logic signed [AW+16:0] sum_x;
  logic signed [AW+16:0] gain_x;
  logic signed [AW+16:0] prod;
  logic                  unused_prod;

  always_comb begin
    ym_ext = {ym_in[AW-1], ym_in};
    case (mix)
      MIX_M12DB: ym_mix = ym_ext >>> 2;
      MIX_OFF:   ym_mix = '0;
      default:   ym_mix = ym_ext;
    endcase
    sum_w = ym_mix + {dma_in[AW-1], dma_in};
    // Top two bits disagree only on overflow; clamp toward the sign of the sum.
    if (sum_w[AW] != sum_w[AW-1])
      sum_sat = {sum_w[AW], {(AW-1){~sum_w[AW]}}};
    else
      sum_sat = sum_w[AW-1:0];
  end

  assign sum_x  = {{17{sum_q[AW-1]}}, sum_q};
  assign gain_x = {{(AW+1){1'b0}}, gain_q};
  assign prod   = sum_x * gain_x;
  assign unused_prod = ^{prod[AW+16], prod[15:0]};

  always_ff @(posedge clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      sum_q     <= '0;
      gain_q    <= '0;
      audio_out <= '0;
    end else begin
      sum_q     <= sum_sat;
      gain_q    <= GAIN_LUT[atten];
      audio_out <= prod[AW+15:16];
    end
  end

endmodule

// File: rtl/ste_microwire_lmc1992.sv
// STE Microwire shifter and LMC1992 command decoder driving two lmc_channel
// instances (left and right).
//
//   state    | meaning
//   MW_IDLE  | waiting for a CPU write to the data register
//   MW_SHIFT | 16 bits out, BIT_CYCLES clocks each, data/mask rotating
//   MW_LATCH | one cycle: decode the received word into the settings
module ste_microwire_lmc1992
  import ste_snd_pkg::*;
#(
  parameter int BIT_CYCLES = 8,
  parameter int AW         = 15
) (
  input  logic                 clk_8,
  input  logic                 reset_n,
  input  logic [15:0]          din,
  input  logic                 addr,
  input  logic                 sel,
  input  logic                 uds,
  input  logic                 lds,
  input  logic                 rw,
  output logic [15:0]          dout,
  output logic                 busy,
  input  logic signed [AW-1:0] ym_in_l,
  input  logic signed [AW-1:0] ym_in_r,
  input  logic signed [AW-1:0] dma_in_l,
  input  logic signed [AW-1:0] dma_in_r,
  output logic signed [AW-1:0] audio_out_l,
  output logic signed [AW-1:0] audio_out_r
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(BIT_CYCLES - 1);

  mw_state_e   state;
  logic [15:0] data;
  logic [15:0] mask;
  logic [15:0] rcv;
  logic [4:0]  rcv_cnt;
  logic [TW-1:0] tmr;
  logic [3:0]  bit_cnt;
  logic        wr_done;
  logic        wr_req;
  logic        cpu_wr;
  logic [5:0]  master;
  logic [4:0]  vol_left;
  logic [4:0]  vol_right;
  mix_e        mix;
  logic [3:0]  bass;
  logic [3:0]  treble;
  logic [5:0]  atten_l;
  logic [5:0]  atten_r;
  logic        unused_state;

  // One write per sel assertion, however long the strobes stay up.
  assign wr_req = sel & ~rw & (uds | lds);
  assign cpu_wr = wr_req & ~wr_done;
  assign dout   = !sel ? 16'h0000 : (addr ? data : mask);

  always_ff @(posedge clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MW_IDLE;
      busy      <= 1'b0;
      data      <= '0;
      mask      <= '0;
      rcv       <= '0;
      rcv_cnt   <= '0;
      tmr       <= '0;
      bit_cnt   <= '0;
      wr_done   <= 1'b0;
      master    <= RST_MASTER;
      vol_left  <= RST_LEFT;
      vol_right <= RST_RIGHT;
      mix       <= RST_MIX;
      bass      <= RST_BASS;
      treble    <= RST_TREBLE;
    end else begin
      wr_done <= sel & (wr_done | wr_req);
      case (state)
        MW_IDLE: begin
          if (cpu_wr) begin
            if (addr) begin
              if (uds) data[15:8] <= din[15:8];
              if (lds) data[7:0]  <= din[7:0];
              state   <= MW_SHIFT;
              busy    <= 1'b1;
              tmr     <= TMR_LOAD;
              bit_cnt <= 4'd15;
              rcv     <= '0;
              rcv_cnt <= '0;
            end else begin
              if (uds) mask[15:8] <= din[15:8];
              if (lds) mask[7:0]  <= din[7:0];
            end
          end
        end
        MW_SHIFT: begin
          if (tmr == '0) begin
            tmr  <= TMR_LOAD;
            data <= {data[14:0], data[15]};
            mask <= {mask[14:0], mask[15]};
            if (mask[15]) begin
              rcv <= {rcv[14:0], data[15]};
              if (rcv_cnt != 5'd31) rcv_cnt <= rcv_cnt + 5'd1;
            end
            if (bit_cnt == 4'd0) state <= MW_LATCH;
            else bit_cnt <= bit_cnt - 4'd1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        MW_LATCH: begin
          state <= MW_IDLE;
          busy  <= 1'b0;
          if (rcv_cnt == 5'd11 && rcv[10:9] == LMC_ADDR) begin
            case (rcv[8:6])
              FN_MIX:    mix       <= mix_e'(rcv[1:0]);
              FN_BASS:   bass      <= (rcv[3:0] > 4'd12) ? 4'd12 : rcv[3:0];
              FN_TREBLE: treble    <= (rcv[3:0] > 4'd12) ? 4'd12 : rcv[3:0];
              FN_MASTER: master    <= (rcv[5:0] > 6'd40) ? 6'd40 : rcv[5:0];
              FN_RIGHT:  vol_right <= (rcv[4:0] > 5'd20) ? 5'd20 : rcv[4:0];
              FN_LEFT:   vol_left  <= (rcv[4:0] > 5'd20) ? 5'd20 : rcv[4:0];
              default: ;
            endcase
          end
        end
        default: begin
          state <= MW_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tone settings are held for software but have no effect on the audio path.
  assign unused_state = ^{rcv[15:11], bass, treble};

  assign atten_l = atten_idx(master, vol_left);
  assign atten_r = atten_idx(master, vol_right);

  lmc_channel #(.AW(AW)) u_ch_l (
    .clk_8     (clk_8),
    .reset_n   (reset_n),
    .mix       (mix),
    .ym_in     (ym_in_l),
    .dma_in    (dma_in_l),
    .atten     (atten_l),
    .audio_out (audio_out_l)
  );

  lmc_channel #(.AW(AW)) u_ch_r (
    .clk_8     (clk_8),
    .reset_n   (reset_n),
    .mix       (mix),
    .ym_in     (ym_in_r),
    .dma_in    (dma_in_r),
    .atten     (atten_r),
    .audio_out (audio_out_r)
  );

endmodule

// File: tb/tb_ste_microwire_lmc1992.sv
// Self-checking bench: directed Microwire/LMC1992 scenarios plus randomized
// commands and samples against a behavioural settings/audio model.
module tb_ste_microwire_lmc1992;

  localparam int BITC = 8;

  logic        clk_8 = 1'b0;
  logic        reset_n;
  logic [15:0] din;
  logic        addr, sel, uds, lds, rw;
  logic [15:0] dout;
  logic        busy;
  logic signed [14:0] ym_in_l, ym_in_r, dma_in_l, dma_in_r;
  logic signed [14:0] audio_out_l, audio_out_r;

  int n_chk = 0;
  int n_fail = 0;
  int m_master, m_left, m_right, m_mix;

  ste_microwire_lmc1992 dut (
    .clk_8(clk_8), .reset_n(reset_n), .din(din), .addr(addr), .sel(sel),
    .uds(uds), .lds(lds), .rw(rw), .dout(dout), .busy(busy),
    .ym_in_l(ym_in_l), .ym_in_r(ym_in_r), .dma_in_l(dma_in_l), .dma_in_r(dma_in_r),
    .audio_out_l(audio_out_l), .audio_out_r(audio_out_r)
  );

  always #5 clk_8 = ~clk_8;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_8);
    #1;
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int lut(input int n);
    real x;
    x = 65535.0 * (10.0 ** (-(n % 10) / 10.0));
    for (int d = 0; d < n / 10; d++) x = x / 10.0;
    return $rtoi($floor(x + 0.5));
  endfunction

  function automatic int ref_out(input int ym, input int dma, input int mix, input int n);
    longint s;
    int y;
    if (mix == 2) y = 0;
    else if (mix == 0) y = int'(fdiv(ym, 4));
    else y = ym;
    s = y + dma;
    if (s > 16383) s = 16383;
    if (s < -16384) s = -16384;
    return int'(fdiv(s * lut(n), 65536));
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] d, input int k);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < k; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic model_reset();
    m_master = 40; m_left = 20; m_right = 20; m_mix = 1;
  endtask

  // Collect the masked data bits MSB first, then apply the LMC1992 rules.
  task automatic model_mw(input logic [15:0] mk, input logic [15:0] dt);
    int cnt, r, fn, v;
    cnt = 0; r = 0;
    for (int i = 15; i >= 0; i--)
      if (mk[i]) begin
        r = r * 2 + int'(dt[i]);
        cnt++;
      end
    if (cnt == 11 && (r / 512) % 4 == 2) begin
      fn = (r / 64) % 8;
      v  = r % 64;
      case (fn)
        0: m_mix    = v % 4;
        3: m_master = imin(v, 40);
        4: m_right  = imin(v % 32, 20);
        5: m_left   = imin(v % 32, 20);
        default: ;
      endcase
    end
  endtask

  task automatic cpu_write(input logic a, input logic [15:0] v, input logic u, input logic l);
    addr = a; din = v; uds = u; lds = l; rw = 1'b0; sel = 1'b1;
    tick();
    rw = 1'b1; uds = 1'b0; lds = 1'b0;
  endtask

  task automatic sel_off();
    sel = 1'b0;
    tick();
  endtask

  task automatic aud(input int yl, input int dl, input int yr, input int dr);
    ym_in_l = 15'(yl); dma_in_l = 15'(dl);
    ym_in_r = 15'(yr); dma_in_r = 15'(dr);
    tick();
    tick();
    chk("audio_l", audio_out_l, ref_out(yl, dl, m_mix, (40 - m_master) + (20 - m_left)));
    chk("audio_r", audio_out_r, ref_out(yr, dr, m_mix, (40 - m_master) + (20 - m_right)));
  endtask

  task automatic xfer(input logic [15:0] mk, input logic [15:0] dt);
    int cnt;
    cpu_write(1'b0, mk, 1'b1, 1'b1);
    sel_off();
    cpu_write(1'b1, dt, 1'b1, 1'b1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      if (cnt == 41) chk("dout_rotating", dout, rotl(dt, 5));
      if (cnt == 45) sel = 1'b0;
      if (cnt == 50) begin
        addr = 1'b0; din = ~mk; rw = 1'b0; uds = 1'b1; lds = 1'b1; sel = 1'b1;
      end
      if (cnt == 51) begin
        rw = 1'b1; uds = 1'b0; lds = 1'b0; addr = 1'b1;
      end
      tick();
    end
    chk("busy_cycles", cnt, 16 * BITC + 1);
    sel = 1'b1; rw = 1'b1; addr = 1'b1;
    #1 chk("data_readback", dout, dt);
    addr = 1'b0;
    #1 chk("mask_readback", dout, mk);
    model_mw(mk, dt);
    sel_off();
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  initial begin
    int fn, v, kind;
    logic [15:0] mk, dt;
    logic [10:0] cmd;

    reset_n = 1'b0; din = '0; addr = 1'b0; sel = 1'b0; uds = 1'b0; lds = 1'b0; rw = 1'b1;
    ym_in_l = '0; ym_in_r = '0; dma_in_l = '0; dma_in_r = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_audio_l", audio_out_l, 0);
    reset_n = 1'b1;
    tick();
    sel = 1'b1; addr = 1'b1;
    #1 chk("rst_data", dout, 0);
    addr = 1'b0;
    #1 chk("rst_mask", dout, 0);
    sel = 1'b0;
    #1 chk("dout_unselected", dout, 0);
    tick();

    // Pipeline latency: new inputs show up on the second edge, not the first.
    ym_in_l = 15'sd1000; dma_in_l = 15'sd2000; ym_in_r = 15'sd1000; dma_in_r = 15'sd2000;
    tick();
    chk("latency_1cyc", audio_out_l, 0);
    tick();
    chk("latency_2cyc", audio_out_l, ref_out(1000, 2000, 1, 0));

    // Byte lanes on the mask register.
    cpu_write(1'b0, 16'h07AA, 1'b1, 1'b0);
    sel_off();
    cpu_write(1'b0, 16'h55FF, 1'b0, 1'b1);
    #1 chk("mask_bytes", dout, 16'h07FF);
    sel_off();

    xfer(16'h07FF, 16'h04C0);          // master = 0
    aud(1000, 2000, 1000, 2000);
    xfer(16'h07FF, 16'h04E8);          // master = 40
    xfer(16'h07FF, 16'h054A);          // left = 10
    aud(0, 10000, 0, 10000);
    xfer(16'h0FFF, 16'h04C0);          // 12 bits received: ignored
    aud(0, 10000, 0, 10000);
    xfer(16'h07FF, 16'h0402);          // mix off
    aud(5000, 0, 5000, 0);
    xfer(16'h07FF, 16'h0400);          // ym -12 dB
    aud(5000, 0, 5000, 0);
    aud(-5001, 3, -7, -16384);
    xfer(16'h07FF, 16'h0401);
    aud(16000, 16000, -16000, -16000);
    aud(16383, 16383, -16384, -16384);
    xfer(16'h07FF, 16'h04FF);          // master clamps to 40
    xfer(16'h07FF, 16'h057F);          // left clamps to 20
    aud(12345, -345, -12345, 345);

    for (int t = 0; t < 24; t++) begin
      fn   = int'($urandom_range(0, 7));
      v    = int'($urandom_range(0, 63));
      kind = int'($urandom_range(0, 7));
      cmd  = {2'b10, fn[2:0], v[5:0]};
      if (kind == 0) begin
        mk = 16'($urandom); dt = 16'($urandom);
      end else if (kind == 1) begin
        mk = 16'hFFE0; dt = {cmd, 5'($urandom)};
      end else if (kind == 2) begin
        mk = 16'h07FF; dt = {5'($urandom), 2'b01, fn[2:0], v[5:0]};
      end else begin
        mk = 16'h07FF; dt = {5'($urandom), cmd};
      end
      xfer(mk, dt);
      repeat (3) aud(rnd_s(), rnd_s(), rnd_s(), rnd_s());
    end

    // Reset in the middle of bit 7 of a transfer.
    cpu_write(1'b0, 16'h07FF, 1'b1, 1'b1);
    sel_off();
    cpu_write(1'b1, 16'h04D4, 1'b1, 1'b1);
    repeat (59) tick();
    chk("midxfer_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_data", dout, 0);
    chk("abort_audio_l", audio_out_l, 0);
    chk("abort_audio_r", audio_out_r, 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    sel_off();
    aud(3000, -1000, -3000, 1000);
    xfer(16'h07FF, 16'h04D4);          // master = 20
    aud(3000, -1000, -3000, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
